rca4_arbiter: RTL and testbench
===============================

# rca4_arbiter

Round-robin arbiter and sequencer that shares one 4-bit ripple-carry adder core between several requesters. It captures the winning requester's operands, holds them stable for a fixed settle window so the carry chain can resolve, registers the sum and carry-out, and returns a one-cycle completion pulse to the owner. It sits between the requesting units and the adder datapath and is the only path into that datapath.

## Interface
- `N_REQ`, default 4: number of requesters, minimum 2.
- `W`, default 4: operand and sum width.
- `SETTLE`, default 4: number of cycles the operands are held on the adder before the result is sampled, minimum 1.

- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset. One clock; reset is synchronous and active-low.
- `req`, input, N_REQ: level request per requester.
- `a_in`, input, N_REQ*W: operand A per requester; requester i uses bits [i*W +: W].
- `b_in`, input, N_REQ*W: operand B per requester, packed the same way.
- `gnt`, output, N_REQ: one-hot, high for the owner while an operation is in flight.
- `done`, output, N_REQ: one-hot, one-cycle completion pulse to the owner.
- `sum_o`, output, W: last registered sum.
- `cout_o`, output, 1: last registered carry-out.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE:**
  - If `req` is not 0, the winner is the first set bit searching from `ptr` upward, wrapping modulo N_REQ.
  - On that edge, the winner's operands are captured into `a_r`/`b_r`, `owner` is set to the winner, `cnt` is set to 0, and the FSM moves to RUN.
  - If `req` is 0, the FSM stays in IDLE.
- **RUN:**
  - `cnt` increments each cycle.
  - On the edge where `cnt == SETTLE-1`, `sum_o` and `cout_o` load the adder outputs and the FSM moves to DONE.
- **DONE:**
  - `done[owner]` is 1 for exactly this cycle.
  - On exit, `ptr` becomes (owner+1) mod N_REQ and the FSM moves to IDLE.
- `gnt[owner]` is 1 in RUN and DONE, and 0 otherwise. `busy` equals (state != IDLE).
- Arithmetic: `sum_o` = (a+b) mod 2^W and `cout_o` = bit W of a+b. Carry-in is fixed at 0.
- `sum_o` and `cout_o` hold their values until the next RUN-to-DONE edge.
- Requester contract: hold operands until the grant edge. Operands are don't-care after capture.
- Dropping `req` during RUN does not abort: the operation completes and `done` still pulses.
- If `req[owner]` is still high in the following IDLE cycle, it is treated as a new request. It then has lowest priority because `ptr` has moved past it.
- Requests arriving in RUN or DONE are not acknowledged until the next IDLE.
- Reset with `rst_n` low at any edge:
  - The FSM goes to IDLE; `ptr`, `owner` and `cnt` go to 0.
  - `gnt`, `done`, `sum_o`, `cout_o` and `busy` go to 0.
  - An in-flight operation is discarded with no `done` pulse.

## Timing
- The request is sampled at edge k in IDLE.
- RUN occupies cycles k+1 .. k+SETTLE.
- DONE occurs in cycle k+SETTLE+1.
- `gnt` is high in cycles k+1 .. k+SETTLE+1.
- The next arbitration is in cycle k+SETTLE+2. Throughput is one operation per SETTLE+2 cycles under continuous demand.
- `sum_o` and `cout_o` are valid from the DONE cycle onward.
- All outputs are registered. There is no combinational path from `req`, `a_in` or `b_in` to any output.
- `cnt` width is $clog2(SETTLE)+1.

## Structure
- Package `rca_pkg` holds:
  - the state enum (IDLE, RUN, DONE),
  - default constants for W, N_REQ and SETTLE,
  - the round-robin pick function (req, ptr) -> index.
- Sub-module `rca_core`: a combinational W-bit ripple chain of full adders with inputs `a`, `b` and outputs `s`, `cout`. It is instantiated once on `a_r`/`b_r`.
- The top level contains the FSM, the counter, the round-robin pointer and the output registers.

## Test plan
- **Single request:** reset, then `req`=0010 with a1=3 and b1=5. Required response:
  - `gnt`=0010 for 5 cycles (SETTLE=4);
  - `done`=0010 for 1 cycle, 5 cycles after the sample edge;
  - `sum_o`=8, `cout_o`=0.
- **Overflow:** a0=15, b0=15. Required response: `sum_o`=14, `cout_o`=1. A following operation 0+0 gives `sum_o`=0, `cout_o`=0.
- **Round-robin:** hold `req`=1111 continuously with distinct operands. Required response:
  - `done` sequence is 0001, 0010, 0100, 1000, 0001;
  - each result matches its own requester's operands;
  - `done` pulses are spaced exactly 6 cycles apart.
- **Priority after completion:** `req`=0101 with `ptr`=0. Required response: requester 0 is served first, then requester 2, even though requester 0 keeps `req` high.
- **Abort-free drop:** deassert `req[1]` and change a1/b1 in the second RUN cycle. Required response: `done[1]` still pulses with the originally captured sum.
- **Reset mid-operation:** assert `rst_n`=0 for one edge during RUN. Required response:
  - all outputs are 0 the next cycle, with no `done` pulse;
  - the FSM is in IDLE;
  - the next request is arbitrated from `ptr`=0.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared types, default sizes and the round-robin pick used by the
// rca4_arbiter block.
package rca_pkg;

  localparam int W_DEF      = 4;
  localparam int N_REQ_DEF  = 4;
  localparam int SETTLE_DEF = 4;

  // Widest request vector the pick function accepts.
  localparam int MAX_REQ    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // First set bit of req searching upward from ptr, wrapping modulo n.
  // Returns 0 when nothing is set; callers only use it when req != 0.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req,
                                 input int                 ptr,
                                 input int                 n);
    int   idx;
    logic found;
    rr_pick = 0;
    found   = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = (ptr + i) % n;
      if (!found && (i < n) && req[5'(idx)]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rca_core.sv
// Combinational W-bit ripple-carry adder built from a chain of full adders.
// Carry-in is tied to zero.
module rca_core #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/rca4_arbiter.sv
// Round-robin arbiter and sequencer in front of one shared ripple-carry
// adder. Captures the winner's operands, holds them for SETTLE cycles so
// the carry chain resolves, registers the result and pulses done.
module rca4_arbiter
  import rca_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int W      = W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_in,
  input  logic [N_REQ*W-1:0] b_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [W-1:0]       sum_o,
  output logic               cout_o,
  output logic               busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(SETTLE) + 1;

  state_t            state;
  state_t            state_next;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  owner;
  logic [PTR_W-1:0]  winner;
  logic [CNT_W-1:0]  cnt;
  logic [W-1:0]      a_r;
  logic [W-1:0]      b_r;
  logic [W-1:0]      core_s;
  logic              core_cout;
  logic              settle_hit;

  assign winner     = PTR_W'(rr_pick(MAX_REQ'(req), int'(ptr), N_REQ));
  assign settle_hit = (cnt == CNT_W'(SETTLE - 1));

  // The captured operands drive the shared adder for the whole settle window.
  rca_core #(.W(W)) u_core (
    .a    (a_r),
    .b    (b_r),
    .s    (core_s),
    .cout (core_cout)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values of the others, independent of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: arbitrate in IDLE, count in RUN, single-cycle DONE.
  always_comb begin
    // NOTE: assign a default first so no path leaves state_next unwritten,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (|req)      state_next = RUN;
      RUN:     if (settle_hit) state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Outputs decoded from registered state and owner only.
  always_comb begin
    gnt  = '0;
    done = '0;
    busy = (state != IDLE);
    if (state != IDLE) gnt[owner]  = 1'b1;
    if (state == DONE) done[owner] = 1'b1;
  end

  // Operand capture, settle counter, result registers and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the operand and result registers are reset too, so an aborted
      // operation leaves nothing stale visible on sum_o/cout_o.
      ptr    <= '0;
      owner  <= '0;
      cnt    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      sum_o  <= '0;
      cout_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner <= winner;
            cnt   <= '0;
            a_r   <= a_in[int'(winner)*W +: W];
            b_r   <= b_in[int'(winner)*W +: W];
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (settle_hit) begin
            sum_o  <= core_s;
            cout_o <= core_cout;
          end
        end
        DONE: begin
          // Move past the owner so it gets lowest priority next round.
          if (owner == PTR_W'(N_REQ - 1)) ptr <= '0;
          else                            ptr <= owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rca4_arbiter.sv
// Self-checking bench for rca4_arbiter: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a timeline model.
module tb_rca4_arbiter;

  localparam int N = 4;
  localparam int W = 4;
  localparam int S = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   sum_o;
  logic           cout_o;
  logic           busy;

  int tests;
  int fails;
  int cyc;

  rca4_arbiter #(.N_REQ(N), .W(W), .SETTLE(S)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .a_in   (a_in),
    .b_in   (b_in),
    .gnt    (gnt),
    .done   (done),
    .sum_o  (sum_o),
    .cout_o (cout_o),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    int           idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [N-1:0] exp_done;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},  32'(gnt),    32'd0);
    check({tag, "_done"}, 32'(done),   32'd0);
    check({tag, "_sum"},  32'(sum_o),  32'd0);
    check({tag, "_cout"}, 32'(cout_o), 32'd0);
    check({tag, "_busy"}, 32'(busy),   32'd0);
  endtask

  // Steps until a done pulse appears; n = edges taken, g = cycles with gnt.
  task automatic wait_done(input int budget, output logic [N-1:0] d,
                           output int n, output int g);
    d = '0;
    n = 0;
    g = 0;
    while (d == '0 && n < budget) begin
      step();
      n++;
      if (gnt != '0) g++;
      d = done;
    end
    if (d == '0) begin
      tests++;
      fails++;
      $display("FAIL wait_done: no done pulse within %0d cycles", budget);
    end
  endtask

  vec_t         vecs[6];
  logic [N-1:0] d;
  int           n;
  int           g;
  int           last;
  logic [W:0]   full;

  // Random-phase model state.
  int           next_arb;
  int           act_k;
  int           act_own;
  int           m_ptr;
  logic [W:0]   pend;
  logic [W-1:0] m_sum;
  logic         m_cout;
  logic [N-1:0] exp_gnt;
  logic [N-1:0] exp_done;

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    rst_n = 1'b1;
    req   = '0;
    a_in  = '0;
    b_in  = '0;

    vecs[0] = '{req: 4'b0010, idx: 1, a: 4'd3,  b: 4'd5,  exp_done: 4'b0010, exp_sum: 4'd8,  exp_cout: 1'b0};
    vecs[1] = '{req: 4'b0001, idx: 0, a: 4'd15, b: 4'd15, exp_done: 4'b0001, exp_sum: 4'd14, exp_cout: 1'b1};
    vecs[2] = '{req: 4'b0100, idx: 2, a: 4'd0,  b: 4'd0,  exp_done: 4'b0100, exp_sum: 4'd0,  exp_cout: 1'b0};
    vecs[3] = '{req: 4'b1000, idx: 3, a: 4'd9,  b: 4'd8,  exp_done: 4'b1000, exp_sum: 4'd1,  exp_cout: 1'b1};
    vecs[4] = '{req: 4'b0110, idx: 1, a: 4'd7,  b: 4'd2,  exp_done: 4'b0010, exp_sum: 4'd9,  exp_cout: 1'b0};
    vecs[5] = '{req: 4'b0011, idx: 0, a: 4'd10, b: 4'd6,  exp_done: 4'b0001, exp_sum: 4'd0,  exp_cout: 1'b1};

    // Reset state.
    step();
    do_reset();
    check_all_zero("reset");

    // Directed vector table, each started from IDLE.
    for (int v = 0; v < 6; v++) begin
      set_ops(vecs[v].idx, vecs[v].a, vecs[v].b);
      req = vecs[v].req;
      wait_done(20, d, n, g);
      req = '0;
      check($sformatf("vec%0d_done", v),    32'(d),      32'(vecs[v].exp_done));
      check($sformatf("vec%0d_latency", v), 32'(n),      32'(S + 1));
      check($sformatf("vec%0d_gnt_len", v), 32'(g),      32'(S + 1));
      check($sformatf("vec%0d_sum", v),     32'(sum_o),  32'(vecs[v].exp_sum));
      check($sformatf("vec%0d_cout", v),    32'(cout_o), 32'(vecs[v].exp_cout));
      step();
      check($sformatf("vec%0d_idle", v),    32'({busy, done}), 32'd0);
    end

    // Round-robin under continuous demand.
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, W'(i*3 + 1), W'(i*4 + 2));
    req  = 4'b1111;
    last = 0;
    for (int j = 0; j < 5; j++) begin
      wait_done(20, d, n, g);
      full = (W+1)'((j % N)*3 + 1) + (W+1)'((j % N)*4 + 2);
      check($sformatf("rr%0d_done", j), 32'(d),      32'(1 << (j % N)));
      check($sformatf("rr%0d_sum", j),  32'(sum_o),  32'(full[W-1:0]));
      check($sformatf("rr%0d_cout", j), 32'(cout_o), 32'(full[W]));
      if (j > 0) check($sformatf("rr%0d_spacing", j), 32'(cyc - last), 32'(S + 2));
      last = cyc;
    end
    req = '0;
    step();

    // Priority after completion: 0 first, then 2 although 0 stays requesting.
    do_reset();
    set_ops(0, 4'd2, 4'd3);
    set_ops(2, 4'd4, 4'd4);
    req = 4'b0101;
    wait_done(20, d, n, g);
    check("prio_first",     32'(d),     32'b0001);
    check("prio_first_sum", 32'(sum_o), 32'd5);
    wait_done(20, d, n, g);
    check("prio_second",     32'(d),     32'b0100);
    check("prio_second_sum", 32'(sum_o), 32'd8);
    req = '0;
    step();

    // Dropping req and changing operands mid-RUN does not abort.
    set_ops(1, 4'd6, 4'd7);
    req = 4'b0010;
    step();
    step();
    req = '0;
    set_ops(1, 4'd15, 4'd15);
    wait_done(20, d, n, g);
    check("drop_done", 32'(d),      32'b0010);
    check("drop_sum",  32'(sum_o),  32'd13);
    check("drop_cout", 32'(cout_o), 32'd0);
    step();

    // Reset mid-operation with a non-zero pointer.
    do_reset();
    set_ops(1, 4'd1, 4'd1);
    req = 4'b0010;
    wait_done(20, d, n, g);
    req = '0;
    step();
    set_ops(0, 4'd5, 4'd5);
    req = 4'b0001;
    step();
    step();
    rst_n = 1'b0;
    req   = '0;
    step();
    rst_n = 1'b1;
    check_all_zero("midrst");
    g = 0;
    for (int i = 0; i < S + 3; i++) begin
      step();
      if (done != '0 || busy) g++;
    end
    check("midrst_no_done", 32'(g), 32'd0);
    set_ops(1, 4'd2, 4'd2);
    set_ops(3, 4'd9, 4'd9);
    req = 4'b1010;
    wait_done(20, d, n, g);
    check("midrst_ptr0_winner", 32'(d),     32'b0010);
    check("midrst_ptr0_sum",    32'(sum_o), 32'd4);
    req = '0;
    step();

    // Randomized traffic against a timeline model of the arbitration rules.
    do_reset();
    next_arb = 0;
    act_k    = -1;
    act_own  = 0;
    m_ptr    = 0;
    pend     = '0;
    m_sum    = '0;
    m_cout   = 1'b0;
    for (int e = 0; e < 800; e++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      req   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      a_in  = (N*W)'($urandom);
      b_in  = (N*W)'($urandom);

      if (!rst_n) begin
        m_ptr    = 0;
        next_arb = e + 1;
        act_k    = -1;
        m_sum    = '0;
        m_cout   = 1'b0;
      end else begin
        if (e >= next_arb && req != '0) begin
          for (int i = N - 1; i >= 0; i--)
            if (req[(m_ptr + i) % N]) act_own = (m_ptr + i) % N;
          act_k    = e;
          pend     = (W+1)'(a_in[act_own*W +: W]) + (W+1)'(b_in[act_own*W +: W]);
          next_arb = e + S + 2;
          m_ptr    = (act_own + 1) % N;
        end
        if (act_k >= 0 && e == act_k + S) begin
          m_sum  = pend[W-1:0];
          m_cout = pend[W];
        end
      end
      exp_gnt  = (act_k >= 0 && e >= act_k && e <= act_k + S) ? N'(1 << act_own) : '0;
      exp_done = (act_k >= 0 && e == act_k + S) ? N'(1 << act_own) : '0;

      step();
      check($sformatf("rand%0d_gnt", e),  32'(gnt),    32'(exp_gnt));
      check($sformatf("rand%0d_done", e), 32'(done),   32'(exp_done));
      check($sformatf("rand%0d_sum", e),  32'(sum_o),  32'(m_sum));
      check($sformatf("rand%0d_cout", e), 32'(cout_o), 32'(m_cout));
      check($sformatf("rand%0d_busy", e), 32'(busy),   32'(exp_gnt != '0));
    end
    rst_n = 1'b1;
    req   = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
